// File: rtl/univ_shift_reg.sv
// Universal shift register: parallel load, clear, and timed multi-step shifts/rotates
// issued through a valid/ready command port, with a one-cycle done pulse per command.
module univ_shift_reg #(
    parameter int DATA_WIDTH = 8,
    parameter int TICK_DIV   = 50_000_000,
    localparam int CNT_W     = $clog2(DATA_WIDTH) + 1
) (
    input  logic                  i_clk,
    input  logic                  rst,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [2:0]            cmd_op,
    input  logic [CNT_W-1:0]      cmd_cnt,
    input  logic [DATA_WIDTH-1:0] d_in,
    input  logic                  a_in,
    output logic [DATA_WIDTH-1:0] o_TEMPout,
    output logic                  s_out,
    output logic                  busy,
    output logic                  done
);

    localparam int TICK_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);
    localparam int W = DATA_WIDTH;

    localparam logic [2:0] OP_NOP  = 3'd0;
    localparam logic [2:0] OP_LOAD = 3'd1;
    localparam logic [2:0] OP_SHL  = 3'd2;
    localparam logic [2:0] OP_SHR  = 3'd3;
    localparam logic [2:0] OP_ROL  = 3'd4;
    localparam logic [2:0] OP_ROR  = 3'd5;
    localparam logic [2:0] OP_ASR  = 3'd6;
    localparam logic [2:0] OP_CLR  = 3'd7;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t          state_q, state_d;
    logic [2:0]      op_q, op_d;
    logic [CNT_W-1:0] rem_q, rem_d;
    logic [TICK_W-1:0] tick_q, tick_d;
    logic [W-1:0]    data_q, data_d;
    logic            sout_q, sout_d;
    logic            busy_q, busy_d;
    logic            ready_q, ready_d;
    logic            done_q, done_d;

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        rem_d   = rem_q;
        tick_d  = tick_q;
        data_d  = data_q;
        sout_d  = sout_q;

        case (state_q)
            S_IDLE: begin
                if (cmd_valid) begin
                    op_d   = cmd_op;
                    tick_d = '0;
                    case (cmd_op)
                        OP_LOAD: begin
                            data_d  = d_in;
                            sout_d  = 1'b0;
                            state_d = S_DONE;
                        end
                        OP_CLR: begin
                            data_d  = '0;
                            sout_d  = 1'b0;
                            state_d = S_DONE;
                        end
                        OP_NOP: state_d = S_DONE;
                        default: begin
                            rem_d   = cmd_cnt;
                            state_d = (cmd_cnt == '0) ? S_DONE : S_RUN;
                        end
                    endcase
                end
            end
            S_RUN: begin
                if (tick_q == TICK_LAST) begin
                    tick_d = '0;
                    rem_d  = rem_q - CNT_W'(1);
                    case (op_q)
                        OP_SHL: begin
                            data_d = {data_q[W-2:0], a_in};
                            sout_d = data_q[W-1];
                        end
                        OP_SHR: begin
                            data_d = {a_in, data_q[W-1:1]};
                            sout_d = data_q[0];
                        end
                        OP_ROL: begin
                            data_d = {data_q[W-2:0], data_q[W-1]};
                            sout_d = data_q[W-1];
                        end
                        OP_ROR: begin
                            data_d = {data_q[0], data_q[W-1:1]};
                            sout_d = data_q[0];
                        end
                        OP_ASR: begin
                            data_d = {data_q[W-1], data_q[W-1:1]};
                            sout_d = data_q[0];
                        end
                        default: ;
                    endcase
                    if (rem_q == CNT_W'(1)) begin
                        state_d = S_DONE;
                    end
                end else begin
                    tick_d = tick_q + TICK_W'(1);
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        // Status flags are registered from the next state so they line up with state_q.
        busy_d  = (state_d != S_IDLE);
        ready_d = (state_d == S_IDLE);
        done_d  = (state_d == S_DONE);
    end

    always_ff @(posedge i_clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            op_q    <= OP_NOP;
            rem_q   <= '0;
            tick_q  <= '0;
            data_q  <= '0;
            sout_q  <= 1'b0;
            busy_q  <= 1'b0;
            ready_q <= 1'b1;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            rem_q   <= rem_d;
            tick_q  <= tick_d;
            data_q  <= data_d;
            sout_q  <= sout_d;
            busy_q  <= busy_d;
            ready_q <= ready_d;
            done_q  <= done_d;
        end
    end

    assign o_TEMPout = data_q;
    assign s_out     = sout_q;
    assign busy      = busy_q;
    assign cmd_ready = ready_q;
    assign done      = done_q;

endmodule

// File: tb/tb_univ_shift_reg.sv
// Scoreboard bench for univ_shift_reg: one instance at TICK_DIV=4, one at TICK_DIV=1.
module tb_univ_shift_reg;

    localparam int W  = 8;
    localparam int CW = 4;

    localparam logic [2:0] NOP = 3'd0, LOAD = 3'd1, SHL = 3'd2, SHR = 3'd3;
    localparam logic [2:0] ROL = 3'd4, ROR = 3'd5, ASR = 3'd6, CLR = 3'd7;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;
    logic v4, v1, a4, a1;
    logic [2:0] op4, op1;
    logic [CW-1:0] cnt4, cnt1;
    logic [W-1:0] d4, d1;
    logic rdy4, rdy1, s4, s1, busy4, busy1, done4, done1;
    logic [W-1:0] q4, q1;

    univ_shift_reg #(.DATA_WIDTH(W), .TICK_DIV(4)) u4 (
        .i_clk(clk), .rst(rst), .cmd_valid(v4), .cmd_ready(rdy4), .cmd_op(op4),
        .cmd_cnt(cnt4), .d_in(d4), .a_in(a4), .o_TEMPout(q4), .s_out(s4),
        .busy(busy4), .done(done4)
    );

    univ_shift_reg #(.DATA_WIDTH(W), .TICK_DIV(1)) u1 (
        .i_clk(clk), .rst(rst), .cmd_valid(v1), .cmd_ready(rdy1), .cmd_op(op1),
        .cmd_cnt(cnt1), .d_in(d1), .a_in(a1), .o_TEMPout(q1), .s_out(s1),
        .busy(busy1), .done(done1)
    );

    int total  = 0;
    int passed = 0;
    logic [W:0] exp4[$];
    logic [W:0] exp1[$];
    logic [W:0] e4, e1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        total++;
        if (act === expv) passed++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, expv);
    endtask

    // Scoreboard monitors: every done pulse retires one expected {s_out, data}.
    always @(negedge clk) begin
        if (!rst && done4) begin
            if (exp4.size() == 0) chk("u4 unexpected done", 32'(done4), 32'(0));
            else begin
                e4 = exp4.pop_front();
                chk("u4 result", 32'({s4, q4}), 32'(e4));
                $display("u4 txn done: q=0x%02h s_out=%0b (exp q=0x%02h s_out=%0b)", q4, s4, e4[W-1:0], e4[W]);
            end
        end
    end

    always @(negedge clk) begin
        if (!rst && done1) begin
            if (exp1.size() == 0) chk("u1 unexpected done", 32'(done1), 32'(0));
            else begin
                e1 = exp1.pop_front();
                chk("u1 result", 32'({s1, q1}), 32'(e1));
                $display("u1 txn done: q=0x%02h s_out=%0b (exp q=0x%02h s_out=%0b)", q1, s1, e1[W-1:0], e1[W]);
            end
        end
    end

    task automatic wait_ready(input bit sel);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(sel ? rdy1 : rdy4) && n < 500);
        if (!(sel ? rdy1 : rdy4)) chk("ready timeout", 32'(sel ? rdy1 : rdy4), 32'(1));
    endtask

    // Drive one command for a single cycle; returns at the negedge after the accept edge.
    task automatic issue(input bit sel, input logic [2:0] op, input logic [CW-1:0] cnt,
                         input logic [W-1:0] d, input logic a, input bit push,
                         input logic [W:0] ex);
        wait_ready(sel);
        if (sel) begin
            v1 = 1'b1; op1 = op; cnt1 = cnt; d1 = d; a1 = a;
            if (push) exp1.push_back(ex);
        end else begin
            v4 = 1'b1; op4 = op; cnt4 = cnt; d4 = d; a4 = a;
            if (push) exp4.push_back(ex);
        end
        @(negedge clk);
        if (sel) v1 = 1'b0;
        else     v4 = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        v4 = 0; op4 = NOP; cnt4 = '0; d4 = '0; a4 = 0;
        v1 = 0; op1 = NOP; cnt1 = '0; d1 = '0; a1 = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("reset q", 32'(q4), 32'(0));
        chk("reset s_out", 32'(s4), 32'(0));
        chk("reset busy", 32'(busy4), 32'(0));
        chk("reset done", 32'(done4), 32'(0));
        chk("reset ready", 32'(rdy4), 32'(1));
        chk("reset u1 ready", 32'(rdy1), 32'(1));

        // TICK_DIV=4 step timing
        issue(0, LOAD, 4'd0, 8'hA5, 1'b0, 1, {1'b0, 8'hA5});
        issue(0, SHL, 4'd3, 8'h00, 1'b1, 1, {1'b1, 8'h2F});
        for (int k = 1; k <= 13; k++) begin
            @(negedge clk);
            if (k == 3)  chk("shl no early step", 32'(q4), 32'(8'hA5));
            if (k == 4)  chk("shl step1", 32'({s4, q4}), 32'({1'b1, 8'h4B}));
            if (k == 8)  chk("shl step2", 32'({s4, q4}), 32'({1'b0, 8'h97}));
            if (k == 12) chk("shl step3", 32'({s4, q4}), 32'({1'b1, 8'h2F}));
            if (k == 11) chk("shl done early", 32'(done4), 32'(0));
            if (k == 12) chk("shl done pulse", 32'(done4), 32'(1));
            if (k == 13) chk("shl done width", 32'(done4), 32'(0));
        end

        // TICK_DIV=1 op coverage
        issue(1, LOAD, 4'd0, 8'h81, 1'b0, 1, {1'b0, 8'h81});
        issue(1, ROR,  4'd8, 8'h00, 1'b0, 1, {1'b1, 8'h81});
        issue(1, LOAD, 4'd0, 8'h80, 1'b0, 1, {1'b0, 8'h80});
        issue(1, ASR,  4'd2, 8'h00, 1'b0, 1, {1'b0, 8'hE0});
        issue(1, LOAD, 4'd0, 8'h01, 1'b0, 1, {1'b0, 8'h01});
        issue(1, SHR,  4'd9, 8'h00, 1'b0, 1, {1'b0, 8'h00});
        issue(1, LOAD, 4'd0, 8'h81, 1'b0, 1, {1'b0, 8'h81});
        issue(1, ROL,  4'd9, 8'h00, 1'b0, 1, {1'b1, 8'h03});
        issue(1, LOAD, 4'd0, 8'h5A, 1'b0, 1, {1'b0, 8'h5A});
        issue(1, SHL,  4'd2, 8'h00, 1'b1, 1, {1'b1, 8'h6B});
        issue(1, NOP,  4'd5, 8'hFF, 1'b0, 1, {1'b1, 8'h6B});
        issue(1, CLR,  4'd0, 8'hFF, 1'b0, 1, {1'b0, 8'h00});
        wait_ready(1);

        // cmd_valid held through a busy period
        issue(0, LOAD, 4'd0, 8'h3C, 1'b0, 1, {1'b0, 8'h3C});
        wait_ready(0);
        v4 = 1'b1; op4 = SHL; cnt4 = 4'd1; a4 = 1'b0;
        exp4.push_back({1'b0, 8'h78});
        @(negedge clk);
        op4 = ROR; cnt4 = 4'd2;
        exp4.push_back({1'b0, 8'h1E});
        chk("hold busy", 32'(busy4), 32'(1));
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            if (k == 4) chk("hold not ready in done", 32'(rdy4), 32'(0));
            if (k == 5) chk("hold idle ready", 32'({busy4, rdy4}), 32'({1'b0, 1'b1}));
            if (k == 6) chk("hold accepted after idle", 32'(busy4), 32'(1));
        end
        v4 = 1'b0;
        issue(0, ROL, 4'd0, 8'h00, 1'b0, 1, {1'b0, 8'h1E});
        chk("rol cnt0 done next cycle", 32'(done4), 32'(1));
        chk("rol cnt0 q unchanged", 32'(q4), 32'(8'h1E));

        // Inputs changed during RUN are ignored
        issue(0, LOAD, 4'd0, 8'h96, 1'b0, 1, {1'b0, 8'h96});
        issue(0, ROR,  4'd3, 8'h96, 1'b0, 1, {1'b1, 8'hD2});
        op4 = CLR; d4 = 8'hFF; cnt4 = 4'd0; a4 = 1'b1;
        wait_ready(0);

        // Reset mid-operation
        issue(0, LOAD, 4'd0, 8'h0F, 1'b0, 1, {1'b0, 8'h0F});
        issue(0, SHL,  4'd5, 8'h00, 1'b1, 0, '0);
        repeat (8) @(negedge clk);
        chk("mid-op after 2 steps", 32'(q4), 32'(8'h3F));
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort q", 32'(q4), 32'(0));
        chk("abort busy", 32'(busy4), 32'(0));
        chk("abort s_out", 32'(s4), 32'(0));
        chk("abort ready", 32'(rdy4), 32'(1));
        repeat (30) @(negedge clk);
        chk("abort no done", 32'(done4), 32'(0));

        for (int n = 0; n < 500 && (exp4.size() != 0 || exp1.size() != 0); n++) @(negedge clk);
        chk("u4 queue drained", 32'(exp4.size()), 32'(0));
        chk("u1 queue drained", 32'(exp1.size()), 32'(0));

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/univ_shift_reg.md
UNIV_SHIFT_REG -- requirements
Module: univ_shift_reg

Interface
REQ-001 Parameter DATA_WIDTH, default 8: register width in bits; SHALL be >= 2.
REQ-002 Parameter TICK_DIV, default 50_000_000: i_clk cycles per shift step; SHALL be >= 1, with 1 meaning one step per clock.
REQ-003 Localparam CNT_W = clog2(DATA_WIDTH)+1: width of the shift count.
REQ-004 i_clk  in  1  sole clock; all state SHALL update on its rising edge only, with no derived clocks.
REQ-005 rst  in  1  synchronous, active-high reset.
REQ-006 cmd_valid  in  1  command request.
REQ-007 cmd_ready  out  1  block can accept a command.
REQ-008 cmd_op  in  3  opcode: 0 NOP, 1 LOAD, 2 SHL, 3 SHR, 4 ROL, 5 ROR, 6 ASR, 7 CLR.
REQ-009 cmd_cnt  in  CNT_W  number of shift steps.
REQ-010 d_in  in  DATA_WIDTH  parallel load data.
REQ-011 a_in  in  1  serial input, sampled at each SHL/SHR step edge.
REQ-012 o_TEMPout  out  DATA_WIDTH  register contents.
REQ-013 s_out  out  1  last bit shifted or rotated out.
REQ-014 busy  out  1  high whenever state is not IDLE.
REQ-015 done  out  1  one-cycle completion pulse.

Function
REQ-016 FSM states: IDLE, RUN, DONE; cmd_ready SHALL be 1 only in IDLE.
REQ-017 Accept SHALL occur on an edge with cmd_valid=1 and cmd_ready=1; cmd_op and cmd_cnt are latched at accept, and input changes afterwards are ignored.
REQ-018 LOAD: o_TEMPout <= d_in and s_out <= 0 on the accept edge; then go to DONE.
REQ-019 CLR: o_TEMPout <= 0 and s_out <= 0 on the accept edge; then go to DONE.
REQ-020 NOP, or any shift op with cmd_cnt=0: no register change; go to DONE.
REQ-021 Shift op with cmd_cnt>0: go to RUN with remaining=cmd_cnt and the tick counter set to 0.
REQ-022 Tick counter: counts only in RUN; a step fires on the edge where the count equals TICK_DIV-1, and the counter then wraps to 0. The first step therefore lands TICK_DIV edges after accept.
REQ-023 Step semantics, q = o_TEMPout, W = DATA_WIDTH:
  - SHL: q <= {q[W-2:0], a_in}, s_out <= q[W-1]
  - SHR: q <= {a_in, q[W-1:1]}, s_out <= q[0]
  - ROL: q <= {q[W-2:0], q[W-1]}, s_out <= q[W-1]
  - ROR: q <= {q[0], q[W-1:1]}, s_out <= q[0]
  - ASR: q <= {q[W-1], q[W-1:1]}, s_out <= q[0]
REQ-024 Each step SHALL decrement remaining; the step that brings remaining to 0 SHALL also move the FSM to DONE.
REQ-025 cmd_cnt > W SHALL be honoured literally (no saturation): shifts fill fully, rotates wrap modulo W.
REQ-026 DONE lasts exactly one cycle with done=1, then returns to IDLE; back-to-back command throughput is one command per (steps*TICK_DIV + 2) cycles.
REQ-027 s_out SHALL hold its value between steps and while in IDLE.
REQ-028 cmd_valid asserted while busy is neither accepted nor queued.

Reset
REQ-029 rst=1 on an edge SHALL set o_TEMPout=0, s_out=0, state=IDLE, tick counter=0, remaining=0, done=0; rst SHALL take priority over any command or step on the same edge.
REQ-030 Reset during RUN SHALL abort with no done pulse; cmd_ready=1 in the first cycle after rst deasserts.

Verification (W=8)
REQ-031 Reset: hold rst for 2 cycles -> o_TEMPout=0x00, s_out=0, busy=0, done=0, cmd_ready=1.
REQ-032 TICK_DIV=4: LOAD 0xA5, then SHL cnt=3 with a_in=1 -> o_TEMPout 0x4B, 0x97, 0x2F on edges 4, 8, 12 after accept; s_out 1, 0, 1; done high only in the cycle after edge 12.
REQ-033 TICK_DIV=1: LOAD 0x81, ROR cnt=8 -> 0x81, s_out=1. LOAD 0x80, ASR cnt=2 -> 0xE0, s_out=0. LOAD 0x01, SHR cnt=9 with a_in=0 -> 0x00.
REQ-034 Reset mid-operation: SHL cnt=5 in progress, rst pulsed after 2 steps -> o_TEMPout=0x00, busy=0, no done pulse, cmd_ready=1 next cycle.
REQ-035 Handshake: cmd_valid held high through a busy period -> not accepted until the first IDLE cycle after DONE. ROL cnt=0 -> done one cycle later, o_TEMPout unchanged.
REQ-036 Ignored inputs: change cmd_op and d_in during RUN -> the result depends only on the values latched at accept.
